// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative RISC-V M-extension unit behind a valid/ready handshake.
// Base ops retire after one cycle; MUL/DIV families take a fixed WIDTH-step shift/subtract loop.
module alu_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);
  localparam int unsigned SH_W = $clog2(WIDTH);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpXor  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpAnd  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpSlt  = 4'd8;
  localparam logic [3:0] OpUlt  = 4'd9;
  localparam logic [3:0] OpSgte = 4'd10;
  localparam logic [3:0] OpUgte = 4'd11;
  localparam logic [3:0] OpEq   = 4'd12;
  localparam logic [3:0] OpNeq  = 4'd13;

  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] AllOne = {WIDTH{1'b1}};

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e            state_q;
  logic [SH_W-1:0]   cnt_q;
  logic [2:0]        op_q;
  logic              res_neg_q, spec_q;
  logic [WIDTH-1:0]  spec_val_q, acc_hi_q, acc_lo_q, opnd_q, out_q;
  logic              out_valid_q;

  logic              accept;
  logic [SH_W-1:0]   sh;
  logic [WIDTH-1:0]  alu_res;

  assign in_ready  = rst_n && !flush && (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == StCalc);
  assign sh        = in2[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (opcode[3:0])
      OpAdd:  alu_res = in1 + in2;
      OpSub:  alu_res = in1 - in2;
      OpXor:  alu_res = in1 ^ in2;
      OpOr:   alu_res = in1 | in2;
      OpAnd:  alu_res = in1 & in2;
      OpSll:  alu_res = in1 << sh;
      OpSrl:  alu_res = in1 >> sh;
      OpSra:  alu_res = WIDTH'($signed(in1) >>> sh);
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
      OpUlt:  alu_res = {{(WIDTH-1){1'b0}}, in1 < in2};
      OpSgte: alu_res = {{(WIDTH-1){1'b0}}, $signed(in1) >= $signed(in2)};
      OpUgte: alu_res = {{(WIDTH-1){1'b0}}, in1 >= in2};
      OpEq:   alu_res = {{(WIDTH-1){1'b0}}, in1 == in2};
      OpNeq:  alu_res = {{(WIDTH-1){1'b0}}, in1 != in2};
      default: alu_res = '0;
    endcase
  end

  // Operand conditioning at issue: magnitudes, result sign and the division bypass cases.
  logic             is_div, sgn_a, sgn_b, neg_a, neg_b, res_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] mag_a, mag_b, spec_val;

  always_comb begin
    is_div   = opcode[2];
    sgn_a    = is_div ? !opcode[0] : (opcode[1:0] != 2'd3);
    sgn_b    = is_div ? !opcode[0] : !opcode[1];
    neg_a    = sgn_a && in1[WIDTH-1];
    neg_b    = sgn_b && in2[WIDTH-1];
    mag_a    = neg_a ? -in1 : in1;
    mag_b    = neg_b ? -in2 : in2;
    res_neg  = (is_div && opcode[1]) ? neg_a : (neg_a ^ neg_b);
    div_zero = is_div && (in2 == '0);
    div_ovf  = is_div && !opcode[0] && (in1 == MinNeg) && (in2 == AllOne);
    spec_val = div_zero ? (opcode[1] ? in1 : AllOne) : (opcode[1] ? '0 : MinNeg);
  end

  // One iteration: multiply shifts {hi,lo} right adding the multiplicand,
  // divide shifts {rem,quo} left and subtracts the divisor when it fits.
  logic [WIDTH:0]     sum, r;
  logic [WIDTH-1:0]   diff, step_hi, step_lo, div_val, div_res, mul_res, m_res;
  logic               ge;
  logic [2*WIDTH-1:0] prod, prod_s;

  always_comb begin
    sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    r    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    ge   = (r >= {1'b0, opnd_q});
    diff = r[WIDTH-1:0] - opnd_q;
    if (op_q[2]) begin
      step_hi = ge ? diff : r[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], ge};
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], acc_lo_q[WIDTH-1:1]};
    end
    prod    = {step_hi, step_lo};
    prod_s  = res_neg_q ? -prod : prod;
    mul_res = (op_q[1:0] == 2'd0) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    div_val = op_q[1] ? step_hi : step_lo;
    div_res = res_neg_q ? -div_val : div_val;
    m_res   = spec_q ? spec_val_q : (op_q[2] ? div_res : mul_res);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      res_neg_q   <= 1'b0;
      spec_q      <= 1'b0;
      spec_val_q  <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      opnd_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (accept) begin
        if (!opcode[4]) begin
          out_q       <= alu_res;
          out_valid_q <= 1'b1;
        end else begin
          state_q    <= StCalc;
          cnt_q      <= '0;
          op_q       <= opcode[2:0];
          res_neg_q  <= res_neg;
          spec_q     <= div_zero || div_ovf;
          spec_val_q <= spec_val;
          acc_hi_q   <= '0;
          acc_lo_q   <= is_div ? mag_a : mag_b;
          opnd_q     <= is_div ? mag_b : mag_a;
        end
      end else if (state_q == StCalc) begin
        acc_hi_q <= step_hi;
        acc_lo_q <= step_lo;
        cnt_q    <= cnt_q + 1'b1;
        if (cnt_q == SH_W'(WIDTH - 1)) begin
          out_q       <= m_res;
          out_valid_q <= 1'b1;
          state_q     <= StIdle;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: stimulus pushes expected results, a negedge monitor retires them.
module tb_alu_mdu;
  localparam logic [4:0] ADD = 5'h00, SUB = 5'h01, XOR = 5'h02, SLL = 5'h05, SRL = 5'h06;
  localparam logic [4:0] SRA = 5'h07, SLT = 5'h08, ULT = 5'h09, SGTE = 5'h0A, UGTE = 5'h0B;
  localparam logic [4:0] EQ = 5'h0C, NEQ = 5'h0D, BADOP = 5'h0E;
  localparam logic [4:0] MUL = 5'h10, MULH = 5'h11, MULHSU = 5'h12, MULHU = 5'h13;
  localparam logic [4:0] DIV = 5'h14, DIVU = 5'h15, REM = 5'h16, REMU = 5'h17;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0]  opcode;
  logic [31:0] in1, in2, out;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  typedef struct { logic [31:0] val; string nm; } exp_t;
  typedef struct { logic [4:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] e; string nm; } vec_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   checks = 0, errors = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected no result (cycle %0d)", out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.nm, out, e.val);
      end
      pop_cyc.push_back(cyc);
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input string nm, input bit push, output int acc);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    in1      = a;
    in2      = b;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got in_ready=0 expected 1 within 200 cycles", nm);
      in_valid = 1'b0;
      acc = cyc;
      return;
    end
    if (push) sb.push_back('{val: e, nm: nm});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc = cyc;
  endtask

  // Waits for an M-op result and checks latency, busy duration and in_ready stall.
  task automatic wait_m(input string nm, input int acc);
    int bn = 0, rn = 0, t = 0;
    @(negedge clk);
    while (!out_valid && t < 100) begin
      bn += int'(busy);
      rn += int'(in_ready);
      t++;
      @(negedge clk);
    end
    check({nm, "_latency"}, 32'(cyc - acc), 32'd32);
    check({nm, "_busy_cycles"}, 32'(bn), 32'd32);
    check({nm, "_in_ready_high"}, 32'(rn), 32'd0);
  endtask

  vec_t base_v[10];
  vec_t m_v[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, acc, nv;
    base_v[0] = '{SUB,   32'd5,          32'd7,  32'hFFFFFFFE, "sub"};
    base_v[1] = '{XOR,   32'hF0F0F0F0,   32'hFF00FF00, 32'h0FF00FF0, "xor"};
    base_v[2] = '{SLL,   32'd1,          32'd35, 32'd8,        "sll_mask"};
    base_v[3] = '{SRL,   32'h80000000,   32'd4,  32'h08000000, "srl"};
    base_v[4] = '{SGTE,  32'hFFFFFFFF,   32'd1,  32'd0,        "sgte"};
    base_v[5] = '{UGTE,  32'hFFFFFFFF,   32'd1,  32'd1,        "ugte"};
    base_v[6] = '{EQ,    32'd5,          32'd5,  32'd1,        "eq"};
    base_v[7] = '{NEQ,   32'd5,          32'd5,  32'd0,        "neq"};
    base_v[8] = '{BADOP, 32'd9,          32'd9,  32'd0,        "unknown_op"};
    base_v[9] = '{SLT,   32'd3,          32'hFFFFFFFE, 32'd0,  "slt_pos_neg"};

    m_v[0]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu"};
    m_v[1]  = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf"};
    m_v[2]  = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        "rem_ovf"};
    m_v[3]  = '{DIVU,   32'd123,      32'd0,        32'hFFFFFFFF, "divu_zero"};
    m_v[4]  = '{REMU,   32'd123,      32'd0,        32'd123,      "remu_zero"};
    m_v[5]  = '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_neg"};
    m_v[6]  = '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_neg"};
    m_v[7]  = '{MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, "mulhsu"};
    m_v[8]  = '{MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, "mul_neg"};
    m_v[9]  = '{DIVU,   32'd100,      32'd7,        32'd14,       "divu"};
    m_v[10] = '{REMU,   32'd100,      32'd7,        32'd2,        "remu"};
    m_v[11] = '{DIV,    32'd0,        32'd0,        32'hFFFFFFFF, "div_zero"};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; in1 = '0; in2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out", out, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    issue(ADD, 32'd7, 32'd5, 32'd12, "add", 1'b1, acc);
    @(negedge clk);
    check("add_out_valid", {31'd0, out_valid}, 32'd1);
    check("add_in_ready", {31'd0, in_ready}, 32'd1);

    @(posedge clk); #1;
    pop_cyc.delete();
    issue(SLT, 32'hFFFFFFFF, 32'd1, 32'd1, "slt", 1'b1, a1);
    issue(ULT, 32'hFFFFFFFF, 32'd1, 32'd0, "ult", 1'b1, acc);
    issue(SRA, 32'h80000000, 32'd33, 32'hC0000000, "sra", 1'b1, acc);
    repeat (2) @(negedge clk);
    check("b2b_count", 32'(pop_cyc.size()), 32'd3);
    for (int i = 0; i < pop_cyc.size(); i++) check("b2b_cycle", 32'(pop_cyc[i]), 32'(a1 + i));

    for (int i = 0; i < 10; i++)
      issue(base_v[i].op, base_v[i].a, base_v[i].b, base_v[i].e, base_v[i].nm, 1'b1, acc);

    issue(MULH, 32'h80000000, 32'h80000000, 32'h40000000, "mulh", 1'b1, acc);
    wait_m("mulh", acc);
    for (int i = 0; i < 12; i++) begin
      issue(m_v[i].op, m_v[i].a, m_v[i].b, m_v[i].e, m_v[i].nm, 1'b1, acc);
      wait_m(m_v[i].nm, acc);
    end

    // Backpressure on a finished multiply.
    @(posedge clk); #1; out_ready = 1'b0;
    issue(MUL, 32'd6, 32'd7, 32'd42, "mul_bp", 1'b1, acc);
    wait_m("mul_bp", acc);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_hold", out, 32'd42);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    check("bp_out_valid_after", {31'd0, out_valid}, 32'd0);

    // Flush mid-divide.
    issue(DIVU, 32'd1000, 32'd3, 32'd0, "divu_flush", 1'b0, acc);
    repeat (10) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    nv = 0;
    repeat (40) begin @(negedge clk); nv += int'(out_valid); end
    check("flush_no_result", 32'(nv), 32'd0);

    // Flush blocks a request presented in the same cycle.
    @(negedge clk);
    in_valid = 1'b1; opcode = ADD; in1 = 32'd1; in2 = 32'd1; flush = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_blocks_accept", {31'd0, out_valid}, 32'd0);

    // Reset mid-divide.
    issue(DIVU, 32'd1000, 32'd3, 32'd0, "divu_reset", 1'b0, acc);
    repeat (10) @(posedge clk);
    #1; rst_n = 1'b0;
    @(negedge clk);
    check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out", out, 32'd0);
    nv = 0;
    repeat (40) begin @(negedge clk); nv += int'(out_valid); end
    check("rst_no_result", 32'(nv), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
